// File: rtl/ddr_read_sched_pkg.sv
// Shared constants, FSM encoding and small helpers for the DDR read scheduler.
package ddr_read_sched_pkg;

    localparam int TOTAL_CHN_NUM   = 16;
    localparam int CHN_IDX_BIT     = 4;
    localparam int BURST_LEN       = 4;
    localparam int PTR_BIT         = 18;
    localparam int MAX_OUTSTANDING = 8;
    localparam int DATA_BIT        = 128;

    // One burst of 128-bit words occupies BURST_LEN*16 bytes.
    localparam int BYTE_OFF_BIT = $clog2(BURST_LEN * 16);
    localparam int ADDR_BIT     = CHN_IDX_BIT + PTR_BIT + BYTE_OFF_BIT;
    localparam int BEAT_BIT     = $clog2(BURST_LEN);
    localparam int FIFO_PTR_BIT = $clog2(MAX_OUTSTANDING);
    localparam int OUT_CNT_BIT  = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [2:0] INSTR_RD = 3'b001;
    localparam logic [5:0] CMD_BL   = 6'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_CMD  = 2'd2
    } sched_state_e;

    function automatic logic [TOTAL_CHN_NUM-1:0] chn_onehot(input logic [CHN_IDX_BIT-1:0] idx);
        chn_onehot      = {TOTAL_CHN_NUM{1'b0}};
        chn_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ddr_read_sched_if.sv
// Channel-side and memory-controller-side signals of the read scheduler.
interface ddr_read_sched_if;
    import ddr_read_sched_pkg::*;

    logic [TOTAL_CHN_NUM-1:0] ch_data_rdy;
    logic [TOTAL_CHN_NUM-1:0] buf_bp;
    logic [TOTAL_CHN_NUM-1:0] ch_rd_ack;
    logic                     memc_cmd_en;
    logic [2:0]               memc_cmd_instr;
    logic [5:0]               memc_cmd_bl;
    logic [ADDR_BIT-1:0]      memc_cmd_addr;
    logic                     memc_cmd_full;
    logic                     memc_rd_valid_in;
    logic [DATA_BIT-1:0]      memc_rd_data_in;
    logic [DATA_BIT-1:0]      memc_rd_data;
    logic [TOTAL_CHN_NUM-1:0] memc_rd_valid;
    logic                     err_orphan;

    modport master (
        input  ch_data_rdy, buf_bp, memc_cmd_full, memc_rd_valid_in, memc_rd_data_in,
        output ch_rd_ack, memc_cmd_en, memc_cmd_instr, memc_cmd_bl, memc_cmd_addr,
               memc_rd_data, memc_rd_valid, err_orphan
    );

    modport slave (
        output ch_data_rdy, buf_bp, memc_cmd_full, memc_rd_valid_in, memc_rd_data_in,
        input  ch_rd_ack, memc_cmd_en, memc_cmd_instr, memc_cmd_bl, memc_cmd_addr,
               memc_rd_data, memc_rd_valid, err_orphan
    );

endinterface

// File: rtl/ddr_sched_tag_fifo.sv
// Synchronous FIFO holding the channel index of every issued-but-incomplete burst.
module ddr_sched_tag_fifo
    import ddr_read_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [CHN_IDX_BIT-1:0] push_data,
    output logic [CHN_IDX_BIT-1:0] head,
    output logic                   empty,
    output logic                   full
);

    logic [CHN_IDX_BIT-1:0]  mem_r [MAX_OUTSTANDING];
    logic [FIFO_PTR_BIT-1:0] wr_ptr_r;
    logic [FIFO_PTR_BIT-1:0] rd_ptr_r;
    logic [OUT_CNT_BIT-1:0]  count_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    // Status flags and guarded push/pop strobes.
    always_comb begin
        empty     = (count_r == {OUT_CNT_BIT{1'b0}});
        full      = (count_r == OUT_CNT_BIT'(MAX_OUTSTANDING));
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        head      = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_PTR_BIT{1'b0}};
            rd_ptr_r <= {FIFO_PTR_BIT{1'b0}};
            count_r  <= {OUT_CNT_BIT{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                mem_r[i] <= {CHN_IDX_BIT{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + FIFO_PTR_BIT'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_PTR_BIT'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + OUT_CNT_BIT'(1);
                2'b01:   count_r <= count_r - OUT_CNT_BIT'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ddr_read_sched.sv
// Round-robin read-burst scheduler toward an MCB-style DDR3 controller,
// tagging returned beats with the one-hot channel that requested them.
module ddr_read_sched
    import ddr_read_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    ddr_read_sched_if.master bus
);

    sched_state_e             state_r;
    logic [CHN_IDX_BIT-1:0]   grant_r;
    logic [CHN_IDX_BIT-1:0]   last_grant_r;
    logic [PTR_BIT-1:0]       rd_ptr_r [TOTAL_CHN_NUM];
    logic [ADDR_BIT-1:0]      cmd_addr_r;
    logic [OUT_CNT_BIT-1:0]   outstanding_r;
    logic [BEAT_BIT-1:0]      beat_cnt_r;
    logic [DATA_BIT-1:0]      rd_data_r;
    logic [TOTAL_CHN_NUM-1:0] rd_valid_r;
    logic                     err_orphan_r;

    logic [TOTAL_CHN_NUM-1:0] eligible_s;
    logic [CHN_IDX_BIT-1:0]   pick_s;
    logic                     can_issue_s;
    logic                     issue_s;
    logic                     beat_s;
    logic                     last_beat_s;
    logic [CHN_IDX_BIT-1:0]   tag_head_s;
    logic                     tag_empty_s;
    logic                     tag_full_s;

    // First requesting channel strictly after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [CHN_IDX_BIT-1:0] rr_pick(input logic [TOTAL_CHN_NUM-1:0] req,
                                                       input logic [CHN_IDX_BIT-1:0]   last);
        logic [CHN_IDX_BIT-1:0] idx;
        logic                   found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= TOTAL_CHN_NUM; i++) begin
            idx = last + CHN_IDX_BIT'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Arbitration inputs and the issue/return strobes shared by all blocks.
    always_comb begin
        eligible_s  = bus.ch_data_rdy & ~bus.buf_bp;
        pick_s      = rr_pick(eligible_s, last_grant_r);
        can_issue_s = (outstanding_r < OUT_CNT_BIT'(MAX_OUTSTANDING)) && !tag_full_s;
        issue_s     = (state_r == ST_CMD) && !bus.memc_cmd_full;
        beat_s      = bus.memc_rd_valid_in && !tag_empty_s;
        last_beat_s = beat_s && (beat_cnt_r == BEAT_BIT'(BURST_LEN - 1));
    end

    // Command FSM: IDLE -> ARB (latch grant and address) -> CMD (wait out cmd_full).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= {CHN_IDX_BIT{1'b0}};
            last_grant_r <= CHN_IDX_BIT'(TOTAL_CHN_NUM - 1);
            cmd_addr_r   <= {ADDR_BIT{1'b0}};
            for (int i = 0; i < TOTAL_CHN_NUM; i++) begin
                rd_ptr_r[i] <= {PTR_BIT{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((eligible_s != {TOTAL_CHN_NUM{1'b0}}) && can_issue_s) begin
                        state_r <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (eligible_s == {TOTAL_CHN_NUM{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        grant_r    <= pick_s;
                        cmd_addr_r <= {pick_s, rd_ptr_r[pick_s], {BYTE_OFF_BIT{1'b0}}};
                        state_r    <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!bus.memc_cmd_full) begin
                        rd_ptr_r[grant_r] <= rd_ptr_r[grant_r] + PTR_BIT'(1);
                        last_grant_r      <= grant_r;
                        state_r           <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Issued-but-incomplete burst count; simultaneous issue and completion cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {OUT_CNT_BIT{1'b0}};
        end else begin
            case ({issue_s, last_beat_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_CNT_BIT'(1);
                2'b01:   outstanding_r <= outstanding_r - OUT_CNT_BIT'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Return path: register each beat with its channel tag; beats without a tag are orphans.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r    <= {DATA_BIT{1'b0}};
            rd_valid_r   <= {TOTAL_CHN_NUM{1'b0}};
            beat_cnt_r   <= {BEAT_BIT{1'b0}};
            err_orphan_r <= 1'b0;
        end else begin
            if (beat_s) begin
                rd_data_r  <= bus.memc_rd_data_in;
                rd_valid_r <= chn_onehot(tag_head_s);
                beat_cnt_r <= last_beat_s ? {BEAT_BIT{1'b0}} : beat_cnt_r + BEAT_BIT'(1);
            end else begin
                rd_valid_r <= {TOTAL_CHN_NUM{1'b0}};
            end
            if (bus.memc_rd_valid_in && tag_empty_s) begin
                err_orphan_r <= 1'b1;
            end
        end
    end

    ddr_sched_tag_fifo u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_s),
        .pop       (last_beat_s),
        .push_data (grant_r),
        .head      (tag_head_s),
        .empty     (tag_empty_s),
        .full      (tag_full_s)
    );

    // The controller samples cmd_en together with cmd_full, so the strobe is gated in the CMD cycle.
    assign bus.memc_cmd_en    = issue_s;
    assign bus.ch_rd_ack      = issue_s ? chn_onehot(grant_r) : {TOTAL_CHN_NUM{1'b0}};
    assign bus.memc_cmd_addr  = cmd_addr_r;
    assign bus.memc_cmd_instr = INSTR_RD;
    assign bus.memc_cmd_bl    = CMD_BL;
    assign bus.memc_rd_data   = rd_data_r;
    assign bus.memc_rd_valid  = rd_valid_r;
    assign bus.err_orphan     = err_orphan_r;

endmodule

// File: tb/tb_ddr_read_sched.sv
// Directed and randomized bench for ddr_read_sched against a transaction-level model.
module tb_ddr_read_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_read_sched_if bus_if ();

    ddr_read_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int errors = 0;
    int checks = 0;

    // stimulus variables applied each cycle
    logic [15:0]  rdy_v = 16'h0;
    logic [15:0]  bp_v  = 16'h0;
    logic         full_v = 1'b0;
    logic         vin_v  = 1'b0;
    logic [127:0] din_v  = 128'h0;
    bit           auto_ret = 1'b0;
    int           ret_pct  = 100;

    // reference model
    int           tagq[$];
    int           beats;
    logic [17:0]  mptr [16];
    int           mlast;
    logic [15:0]  exp_valid;
    logic [127:0] exp_data;
    logic         exp_orphan;

    // observations of the latest step
    bit           issued;
    int           gidx;
    logic [27:0]  obs_addr;
    logic [15:0]  obs_ack;
    int           issue_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_ref(input logic [15:0] elig, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (elig[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        tagq.delete();
        beats      = 0;
        mlast      = 15;
        exp_valid  = 16'h0;
        exp_data   = 128'h0;
        exp_orphan = 1'b0;
        for (int c = 0; c < 16; c++) mptr[c] = 18'h0;
    endtask

    // one clock cycle: check registered return path, drive inputs, observe command port
    task automatic step();
        logic [15:0] elig;
        int g;
        @(negedge clk);
        check("rd_valid", bus_if.memc_rd_valid, exp_valid);
        if (exp_valid != 16'h0) check("rd_data", bus_if.memc_rd_data, exp_data);
        check("err_orphan", bus_if.err_orphan, exp_orphan);
        if (auto_ret) begin
            vin_v = (tagq.size() > 0) && ($urandom_range(99) < ret_pct);
            din_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        bus_if.ch_data_rdy      = rdy_v;
        bus_if.buf_bp           = bp_v;
        bus_if.memc_cmd_full    = full_v;
        bus_if.memc_rd_valid_in = vin_v;
        bus_if.memc_rd_data_in  = din_v;
        exp_valid = 16'h0;
        if (vin_v) begin
            if (tagq.size() > 0) begin
                exp_valid = 16'h1 << tagq[0];
                exp_data  = din_v;
                beats++;
                if (beats == 4) begin
                    beats = 0;
                    void'(tagq.pop_front());
                end
            end else begin
                exp_orphan = 1'b1;
            end
        end
        #1;
        issued   = bus_if.memc_cmd_en;
        obs_addr = bus_if.memc_cmd_addr;
        obs_ack  = bus_if.ch_rd_ack;
        if (full_v) check("cmd_en_while_full", bus_if.memc_cmd_en, 1'b0);
        if (issued) begin
            elig = rdy_v & ~bp_v;
            g = rr_ref(elig, mlast);
            if (g < 0) begin
                check("spurious_issue", bus_if.memc_cmd_en, 1'b0);
            end else begin
                check("grant_ack", obs_ack, 16'h1 << g);
                check("cmd_addr", obs_addr, (28'(g) << 24) | (28'(mptr[g]) << 6));
                check("cmd_instr", bus_if.memc_cmd_instr, 3'b001);
                check("cmd_bl", bus_if.memc_cmd_bl, 6'd3);
                check("outstanding_cap", tagq.size() < 8, 1'b1);
                gidx = g;
                tagq.push_back(g);
                mptr[g] = mptr[g] + 18'd1;
                mlast = g;
                issue_cnt++;
            end
        end else begin
            check("ack_idle", obs_ack, 16'h0);
        end
    endtask

    task automatic run_until_issue(input int max, output int n);
        n = 0;
        issued = 1'b0;
        while (!issued && n < max) begin
            step();
            n++;
        end
        check("issue_timeout", issued, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        rdy_v = 16'h0;
        auto_ret = 1'b1;
        ret_pct = 100;
        while ((tagq.size() > 0 || beats != 0) && k < 200) begin
            step();
            k++;
        end
        check("drain_timeout", tagq.size(), 0);
        auto_ret = 1'b0;
        vin_v = 1'b0;
        step();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        rdy_v = 16'h0; bp_v = 16'h0; full_v = 1'b0; vin_v = 1'b0; auto_ret = 1'b0;
        bus_if.ch_data_rdy = 16'h0;
        bus_if.buf_bp = 16'h0;
        bus_if.memc_cmd_full = 1'b0;
        bus_if.memc_rd_valid_in = 1'b0;
        bus_if.memc_rd_data_in = 128'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_cmd_en", bus_if.memc_cmd_en, 1'b0);
        check("rst_ack", bus_if.ch_rd_ack, 16'h0);
        check("rst_addr", bus_if.memc_cmd_addr, 28'h0);
        check("rst_rd_valid", bus_if.memc_rd_valid, 16'h0);
        check("rst_rd_data", bus_if.memc_rd_data, 128'h0);
        check("rst_orphan", bus_if.err_orphan, 1'b0);
        check("rst_instr", bus_if.memc_cmd_instr, 3'b001);
        check("rst_bl", bus_if.memc_cmd_bl, 6'd3);
    endtask

    task automatic rerandomize();
        rdy_v = 16'($urandom() & $urandom());
        bp_v  = 16'($urandom() & $urandom() & $urandom());
    endtask

    initial begin
        int n, c0, stall, rnd_issues, k;
        logic [27:0] held_addr;
        model_reset();
        reset_dut();

        // single channel: latency, address, ack, tagged return of one burst
        rdy_v = 16'h0004;
        run_until_issue(10, n);
        check("sc_latency", n, 3);
        check("sc_addr", obs_addr, 28'h2000000);
        check("sc_ack", obs_ack, 16'h0004);
        rdy_v = 16'h0;
        for (int b = 0; b < 4; b++) begin
            vin_v = 1'b1;
            din_v = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        vin_v = 1'b0;
        step();
        step();

        // fairness with every channel requesting
        reset_dut();
        rdy_v = 16'hFFFF;
        auto_ret = 1'b1;
        ret_pct = 100;
        for (int i = 0; i < 17; i++) begin
            run_until_issue(10, n);
            check("fair_seq", gidx, i % 16);
            check("fair_rate", n, 3);
            if (i == 16) check("fair_ch0_second_addr", obs_addr, 28'h0000040);
        end
        drain();

        // backpressure hides channel 1 until released
        rdy_v = 16'h0003;
        bp_v  = 16'h0002;
        auto_ret = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_until_issue(10, n);
            check("bp_only_ch0", gidx, 0);
        end
        bp_v = 16'h0;
        run_until_issue(10, n);
        check("bp_release_ch1", gidx, 1);
        drain();

        // outstanding limit
        auto_ret = 1'b0;
        vin_v = 1'b0;
        rdy_v = 16'hFFFF;
        c0 = issue_cnt;
        repeat (60) step();
        check("os_cap_8", issue_cnt - c0, 8);
        for (int b = 0; b < 4; b++) begin
            vin_v = 1'b1;
            din_v = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        vin_v = 1'b0;
        repeat (20) step();
        check("os_one_more", issue_cnt - c0, 9);
        drain();

        // cmd_full stall holds CMD with a stable address
        rdy_v = 16'h0008;
        full_v = 1'b1;
        c0 = issue_cnt;
        held_addr = 28'h0;
        for (int s = 0; s < 7; s++) begin
            step();
            if (s == 2) begin
                held_addr = obs_addr;
                check("full_addr", obs_addr, (28'd3 << 24) | (28'(mptr[3]) << 6));
            end
            if (s > 2) check("full_addr_stable", obs_addr, held_addr);
        end
        full_v = 1'b0;
        run_until_issue(3, n);
        check("full_release_latency", n, 1);
        check("full_release_addr", obs_addr, held_addr);
        rdy_v = 16'h0;
        repeat (6) step();
        check("full_single_issue", issue_cnt - c0, 1);
        drain();

        // orphan beat with nothing outstanding
        vin_v = 1'b1;
        din_v = 128'hDEAD;
        step();
        vin_v = 1'b0;
        step();
        check("orphan_flag", bus_if.err_orphan, 1'b1);
        check("orphan_no_valid", bus_if.memc_rd_valid, 16'h0);

        // reset in the middle of a burst; late beats become orphans
        rdy_v = 16'h0010;
        run_until_issue(10, n);
        rdy_v = 16'h0;
        vin_v = 1'b1;
        step();
        step();
        vin_v = 1'b0;
        reset_dut();
        step();
        vin_v = 1'b1;
        step();
        vin_v = 1'b0;
        step();
        step();
        check("post_rst_orphan", bus_if.err_orphan, 1'b1);
        reset_dut();
        rdy_v = 16'h0010;
        run_until_issue(10, n);
        check("post_rst_latency", n, 3);
        check("post_rst_addr", obs_addr, 28'h4000000);
        drain();

        // randomized traffic
        stall = 0;
        rnd_issues = issue_cnt;
        auto_ret = 1'b1;
        ret_pct = 70;
        rerandomize();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            if (issued) begin
                stall = 0;
                if ($urandom_range(99) < 40) rerandomize();
            end else if ((rdy_v & ~bp_v) == 16'h0) begin
                if ($urandom_range(99) < 30) rerandomize();
            end else if (tagq.size() < 8) begin
                stall++;
                if (stall > 40) begin
                    check("liveness", stall, 0);
                    stall = 0;
                end
            end
            full_v = ($urandom_range(99) < 15);
        end
        full_v = 1'b0;
        k = 0;
        while (!issued && ((rdy_v & ~bp_v) != 16'h0) && k < 50) begin
            step();
            k++;
        end
        check("random_activity", (issue_cnt - rnd_issues) > 50, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
